// File: rtl/spi_cmd_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_rx_pkg
// Shared constants and helpers for the SPI command receiver:
//   - bit positions of the flags inside the MISO status byte
//   - width of the saturated occupancy field in the status byte
//   - default command FIFO depth
//   - status_byte(): builds {overflow, frame_err, sat6(count)}
// -----------------------------------------------------------------------------
package spi_cmd_rx_pkg;

  localparam int SPI_STATUS_OVF_BIT     = 7;
  localparam int SPI_STATUS_FERR_BIT    = 6;
  localparam int SPI_STATUS_CNT_WIDTH   = 6;
  localparam int SPI_DEFAULT_FIFO_DEPTH = 16;

  // Widest occupancy value the block can produce (FIFO_DEPTH up to 256).
  localparam int SPI_CNT_EXT_WIDTH      = 9;

  // Occupancy field of the status byte saturates instead of wrapping, so a
  // host never reads a deep FIFO as nearly empty.
  function automatic logic [SPI_STATUS_CNT_WIDTH-1:0] sat_cnt(
    input logic [SPI_CNT_EXT_WIDTH-1:0] cnt
  );
    logic [SPI_STATUS_CNT_WIDTH-1:0] res;
    if (cnt > SPI_CNT_EXT_WIDTH'(63)) begin
      res = '1;
    end else begin
      res = cnt[SPI_STATUS_CNT_WIDTH-1:0];
    end
    return res;
  endfunction

  function automatic logic [7:0] status_byte(
    input logic                         ovf,
    input logic                         ferr,
    input logic [SPI_CNT_EXT_WIDTH-1:0] cnt
  );
    logic [7:0] res;
    res                                 = '0;
    res[SPI_STATUS_OVF_BIT]             = ovf;
    res[SPI_STATUS_FERR_BIT]            = ferr;
    res[SPI_STATUS_CNT_WIDTH-1:0]       = sat_cnt(cnt);
    return res;
  endfunction

endpackage

// File: rtl/spi_cmd_rx_byte_fifo.sv
// -----------------------------------------------------------------------------
// spi_cmd_rx_byte_fifo
// First-word-fall-through byte FIFO feeding the control unit.
//
// Ports:
//   clk, reset    system clock, synchronous active-low reset
//   i_push        push request (one cycle per byte)
//   i_push_data   byte to push
//   i_pop         pop request; ignored while empty
//   o_data        head byte, valid while o_not_empty=1 (0 when empty)
//   o_not_empty   FIFO holds at least one byte
//   o_count       occupancy, $clog2(DEPTH)+1 bits
//   o_drop        push rejected this cycle (full and no pop)
//
// Handshake: o_not_empty acts as "valid" for o_data; a cycle with i_pop=1
// and o_not_empty=1 consumes the head, and the new head/count appear on the
// next cycle. A pop while empty is a no-op. A push together with a pop is
// always accepted, even when full, because the popped slot is the one the
// push lands in.
// -----------------------------------------------------------------------------
module spi_cmd_rx_byte_fifo
  import spi_cmd_rx_pkg::*;
#(
  parameter int DEPTH = SPI_DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_not_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;

  assign o_not_empty = !w_empty;
  assign o_data      = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_count     = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: o_data is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/spi_cmd_rx.sv
// -----------------------------------------------------------------------------
// spi_cmd_rx
// SPI mode-0 slave byte receiver feeding a command FIFO, with a status byte
// returned on MISO so the host can throttle itself.
//
// Ports:
//   clk         system clock (>= 8x sck)
//   reset       synchronous active-low reset
//   sck, cs_n   SPI clock / chip select (asynchronous, synchronised here)
//   mosi        SPI data in, MSB first
//   miso        SPI data out, MSB first: {overflow, frame_err, sat6(count)}
//   out_byte    head-of-FIFO byte, valid while out_ready=1
//   out_ready   FIFO non-empty
//   next        single-cycle pop request
//   fifo_count  current FIFO occupancy
//   overflow    sticky: a byte was dropped on a full FIFO (read-to-clear)
//   frame_err   sticky: cs_n rose mid-byte (read-to-clear)
// Flags clear when the status byte is captured at the start of a frame.
// -----------------------------------------------------------------------------
module spi_cmd_rx
  import spi_cmd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = SPI_DEFAULT_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          cs_n,
  input  logic                          mosi,
  output logic                          miso,
  output logic [7:0]                    out_byte,
  output logic                          out_ready,
  input  logic                          next,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic                   r_cs_prev;
  logic [SYNC_STAGES:0]   r_warm;
  logic                   r_armed;
  logic [6:0]             r_rx_shift;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_tx_shift;
  logic                   r_overflow;
  logic                   r_frame_err;

  logic                   w_sck_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_live;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_rx_bit;
  logic                   w_push;
  logic [7:0]             w_push_data;
  logic                   w_drop;
  logic                   w_frame_evt;
  logic [CW-1:0]          w_fifo_count;
  logic [7:0]             w_status;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // After reset the synchronisers hold preset idle values that may not
  // match the pins; edges are ignored until the preset values have been
  // flushed, so a cs_n already low at reset release never looks like a
  // fresh frame start.
  assign w_live     = r_warm[SYNC_STAGES];

  assign w_sck_rise = w_live &&  w_sck_s && !r_sck_prev;
  assign w_sck_fall = w_live && !w_sck_s &&  r_sck_prev;
  assign w_cs_fall  = w_live && !w_cs_s  &&  r_cs_prev;
  assign w_cs_rise  = w_live &&  w_cs_s  && !r_cs_prev;

  // Bits only count inside a frame that began after the last reset.
  assign w_rx_bit    = w_sck_rise && !w_cs_s && r_armed && !w_cs_fall;
  assign w_push      = w_rx_bit && (r_bit_cnt == 3'd7);
  assign w_push_data = {r_rx_shift, w_mosi_s};
  assign w_frame_evt = w_cs_rise && (r_bit_cnt != 3'd0);

  assign w_status = status_byte(r_overflow, r_frame_err,
                                SPI_CNT_EXT_WIDTH'(w_fifo_count));

  assign miso       = r_tx_shift[7] && !w_cs_s;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;
  assign fifo_count = w_fifo_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_warm      <= '0;
      r_armed     <= 1'b0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_prev  <= w_sck_s;
      r_cs_prev   <= w_cs_s;
      r_warm      <= {r_warm[SYNC_STAGES-1:0], 1'b1};

      // Receive path; frame boundaries take priority over data bits.
      if (w_cs_fall) begin
        r_armed   <= 1'b1;
        r_bit_cnt <= '0;
      end else if (w_cs_rise) begin
        r_bit_cnt <= '0;
      end else if (w_rx_bit) begin
        r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end

      // Status shifter: captured at frame start, then one bit per sck fall;
      // zeros fill in behind so later bytes of the frame read as 0.
      if (w_cs_fall) begin
        r_tx_shift <= w_status;
      end else if (w_sck_fall && !w_cs_s) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      // Read-to-clear at frame start, but an event in that same cycle wins.
      r_overflow  <= (w_cs_fall ? 1'b0 : r_overflow)  || w_drop;
      r_frame_err <= (w_cs_fall ? 1'b0 : r_frame_err) || w_frame_evt;
    end
  end

  spi_cmd_rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (next),
    .o_data      (out_byte),
    .o_not_empty (out_ready),
    .o_count     (w_fifo_count),
    .o_drop      (w_drop)
  );

endmodule

// File: tb/tb_spi_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_rx
// Directed bench for spi_cmd_rx. Bytes sent on MOSI are queued in exp_q as
// they are issued; a monitor pops exp_q and compares out_byte whenever the
// bench pops a byte from the DUT. Flags, counts and MISO status bytes are
// compared against hand-computed constants.
// Timing: clk period 10 ns, sck period 160 ns (clk/16). All SPI activity is
// launched on clk falling edges so sampling points are deterministic.
// -----------------------------------------------------------------------------
module tb_spi_cmd_rx;

  localparam int FIFO_DEPTH = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sck = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          next = 1'b0;
  logic          miso;
  logic [7:0]    out_byte;
  logic          out_ready;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_err;

  always #5 clk = ~clk;

  spi_cmd_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .out_byte   (out_byte),
    .out_ready  (out_ready),
    .next       (next),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // ---------------------------------------------------------------- scoreboard
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Every pop the bench issues must land on a non-empty FIFO holding the
  // byte at the head of exp_q.
  always @(negedge clk) begin
    if (reset && next) begin
      if (!out_ready) begin
        check("pop_ready", 32'(out_ready), 32'h1);
      end else if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(out_byte), 32'hFFFF_FFFF);
      end else begin
        check("pop_data", 32'(out_byte), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- drivers
  task automatic cs_lo();
    cs_n = 1'b0;
    #160;
  endtask

  task automatic cs_hi();
    #160;
    cs_n = 1'b1;
    #160;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #80;
      sck = 1'b1;
      #80;
      sck = 1'b0;
    end
  endtask

  // mode 0: plain byte; mode 1: check push-to-out_ready latency on the last
  // rise; mode 2: pop in the exact cycle the last rise pushes the byte.
  task automatic spi_byte(input logic [7:0] b, input logic exp_push,
                          input int mode, output logic [7:0] m_out);
    if (exp_push) exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      #80;
      m_out[i] = miso;
      sck = 1'b1;
      if (i == 0 && mode == 1) begin
        #20;
        check("lat_early", 32'(out_ready), 32'h0);
        #10;
        check("lat_ready", 32'(out_ready), 32'h1);
        check("lat_byte", 32'(out_byte), 32'(b));
        #50;
      end else if (i == 0 && mode == 2) begin
        #16;
        next = 1'b1;
        #10;
        next = 1'b0;
        #54;
      end else begin
        #80;
      end
      sck = 1'b0;
    end
  endtask

  task automatic pop_one();
    @(posedge clk);
    #1 next = 1'b1;
    @(posedge clk);
    #1 next = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_out_ready", 32'(out_ready), 32'h0);
    check("rst_out_byte", 32'(out_byte), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_miso", 32'(miso), 32'h0);

    // Single byte with exact latency, then pop
    cs_lo();
    spi_byte(8'hA5, 1'b1, 1, m);
    cs_hi();
    check("single_count", 32'(fifo_count), 32'h1);
    pop_one();
    check("single_empty", 32'(out_ready), 32'h0);
    check("single_count0", 32'(fifo_count), 32'h0);

    // Burst of three, popped 2 cycles apart
    cs_lo();
    spi_byte(8'h01, 1'b1, 0, m);
    spi_byte(8'h02, 1'b1, 0, m);
    spi_byte(8'h03, 1'b1, 0, m);
    cs_hi();
    check("burst_count", 32'(fifo_count), 32'h3);
    for (int i = 0; i < 3; i++) begin
      pop_one();
    end
    check("burst_empty", 32'(out_ready), 32'h0);

    // Overflow: 17 bytes into 16 slots, the last is dropped
    cs_lo();
    for (int i = 0; i < 17; i++) begin
      spi_byte(8'(8'h80 + i), (i < 16), 0, m);
    end
    cs_hi();
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_count", 32'(fifo_count), 32'h10);

    // Status frame: reads 0x90, clears overflow; a pop makes room for 0x11
    cs_lo();
    pop_one();
    spi_byte(8'h11, 1'b1, 0, m);
    cs_hi();
    check("ovf_status", 32'(m), 32'h90);
    check("ovf_cleared", 32'(overflow), 32'h0);
    check("ovf_refill", 32'(fifo_count), 32'h10);

    // Collision at full: pop lands in the push cycle of 0x7E
    cs_lo();
    spi_byte(8'h7E, 1'b1, 2, m);
    cs_hi();
    check("coll_status", 32'(m), 32'h10);
    check("coll_no_ovf", 32'(overflow), 32'h0);
    check("coll_count", 32'(fifo_count), 32'h10);
    for (int i = 0; i < 16; i++) begin
      pop_one();
    end
    check("coll_drained", 32'(out_ready), 32'h0);
    check("coll_count0", 32'(fifo_count), 32'h0);

    // Frame error: 5 bits then cs_n high
    cs_lo();
    spi_bits(8'hFF, 5);
    cs_hi();
    check("ferr_flag", 32'(frame_err), 32'h1);
    check("ferr_count", 32'(fifo_count), 32'h0);
    cs_lo();
    spi_byte(8'h3C, 1'b1, 0, m);
    cs_hi();
    check("ferr_status", 32'(m), 32'h40);
    check("ferr_cleared", 32'(frame_err), 32'h0);
    check("ferr_count1", 32'(fifo_count), 32'h1);
    pop_one();

    // Reset mid-transfer with two bytes queued
    cs_lo();
    spi_byte(8'hAA, 1'b1, 0, m);
    spi_byte(8'hBB, 1'b1, 0, m);
    spi_bits(8'hF0, 4);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mrst_out_ready", 32'(out_ready), 32'h0);
    check("mrst_count", 32'(fifo_count), 32'h0);
    check("mrst_flags", 32'({overflow, frame_err}), 32'h0);
    spi_bits(8'h0F, 4);
    spi_byte(8'h99, 1'b0, 0, m);
    check("mrst_ignored", 32'(fifo_count), 32'h0);
    cs_hi();
    check("mrst_no_ferr", 32'(frame_err), 32'h0);
    cs_lo();
    spi_byte(8'h55, 1'b1, 0, m);
    cs_hi();
    check("mrst_status", 32'(m), 32'h00);
    check("mrst_count1", 32'(fifo_count), 32'h1);
    pop_one();

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
